// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared types and constants for the MIPS pipeline hazard
//               controller: FSM state encoding, register-specifier width and
//               the per-stage enable/flush control bundles.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int c_REG_ADDR_W = 3;

    // Hazard-controller FSM encoding
    typedef logic [1:0] state_t;
    localparam state_t c_ST_RUN      = 2'd0;
    localparam state_t c_ST_STALL    = 2'd1;
    localparam state_t c_ST_MEM_WAIT = 2'd2;

    // One bundle carries every enable/flush the controller drives
    typedef struct packed {
        logic pcEn;
        logic pcSelBranch;
        logic ifIdEn;
        logic ifIdFlush;
        logic idExEn;
        logic idExBubble;
        logic exMemEn;
        logic exMemFlush;
    } ctrl_t;

    // Everything low: used while reset is asserted
    localparam ctrl_t c_CTRL_OFF = '{pcEn: 1'b0, pcSelBranch: 1'b0, ifIdEn: 1'b0, ifIdFlush: 1'b0,
                                     idExEn: 1'b0, idExBubble: 1'b0, exMemEn: 1'b0, exMemFlush: 1'b0};
    // Normal flow: every register advances, nothing is squashed
    localparam ctrl_t c_CTRL_RUN = '{pcEn: 1'b1, pcSelBranch: 1'b0, ifIdEn: 1'b1, ifIdFlush: 1'b0,
                                     idExEn: 1'b1, idExBubble: 1'b0, exMemEn: 1'b1, exMemFlush: 1'b0};
    // Whole-pipe freeze while data memory is busy
    localparam ctrl_t c_CTRL_HOLD = '{pcEn: 1'b0, pcSelBranch: 1'b0, ifIdEn: 1'b0, ifIdFlush: 1'b0,
                                      idExEn: 1'b0, idExBubble: 1'b0, exMemEn: 1'b0, exMemFlush: 1'b0};
    // Load-use bubble: PC and IF/ID hold, ID/EX loads zero control
    localparam ctrl_t c_CTRL_BUBBLE = '{pcEn: 1'b0, pcSelBranch: 1'b0, ifIdEn: 1'b0, ifIdFlush: 1'b0,
                                        idExEn: 1'b1, idExBubble: 1'b1, exMemEn: 1'b1, exMemFlush: 1'b0};
    // Taken branch: redirect PC and load NOP/zero control into younger stages
    localparam ctrl_t c_CTRL_FLUSH = '{pcEn: 1'b1, pcSelBranch: 1'b1, ifIdEn: 1'b1, ifIdFlush: 1'b1,
                                       idExEn: 1'b1, idExBubble: 1'b1, exMemEn: 1'b1, exMemFlush: 1'b1};

endpackage
`default_nettype wire

// File: rtl/hazard_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sat_counter
// Description : CNT_W-wide event counter that sticks at all-ones instead of
//               wrapping. Asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count enabled events until the counter is full, then hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush controller for the 16-bit, 8-register pipelined
//               MIPS. Inserts load-use bubbles, flushes on taken branches,
//               freezes the pipe while data memory is busy and keeps
//               saturating stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W      = c_REG_ADDR_W,
    parameter int LOAD_USE_STALLS = 1,
    parameter int IGNORE_R0       = 1,
    parameter int CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_memRead,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  mem_branch_taken,
    input  logic                  dmem_busy,
    output logic                  pc_en,
    output logic                  pc_sel_branch,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_en,
    output logic                  id_ex_bubble,
    output logic                  ex_mem_en,
    output logic                  ex_mem_flush,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // Bubbles still owed after the first one (LOAD_USE_STALLS is at most 3)
    localparam logic [1:0] c_REM_LOAD = 2'(LOAD_USE_STALLS - 1);

    state_t     r_state;
    logic [1:0] r_remaining;
    logic       r_branchPend;

    state_t     w_effState;
    state_t     w_nextState;
    logic [1:0] w_nextRemaining;
    logic       w_nextBranchPend;
    logic       w_hazard;
    logic       w_incStall;
    logic       w_incFlush;
    ctrl_t      w_ctrl;

    // Load in EX writes a register the ID instruction reads; R0 optionally exempt
    assign w_hazard = ex_memRead
                    && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)))
                    && !((IGNORE_R0 != 0) && (ex_rt == '0));

    // State/bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_RUN;
            r_remaining  <= 2'd0;
            r_branchPend <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_remaining  <= w_nextRemaining;
            r_branchPend <= w_nextBranchPend;
        end
    end

    // MEM_WAIT resumes whichever state was frozen: an unfinished stall count means STALL
    always_comb begin
        w_effState = c_ST_RUN;
        case (r_state)
            c_ST_STALL:    w_effState = c_ST_STALL;
            c_ST_MEM_WAIT: w_effState = (r_remaining != 2'd0) ? c_ST_STALL : c_ST_RUN;
            default:       w_effState = c_ST_RUN;
        endcase
    end

    // Next-state and Mealy outputs; busy beats branch beats load-use
    always_comb begin
        w_ctrl           = c_CTRL_RUN;
        w_nextState      = w_effState;
        w_nextRemaining  = r_remaining;
        w_nextBranchPend = r_branchPend;
        w_incStall       = 1'b0;
        w_incFlush       = 1'b0;

        if (dmem_busy) begin
            w_ctrl      = c_CTRL_HOLD;
            w_nextState = c_ST_MEM_WAIT;
            if (mem_branch_taken) begin
                w_nextBranchPend = 1'b1;
            end
        end else if (mem_branch_taken || r_branchPend) begin
            // Hazarding instruction is killed by the flush, so hz is ignored
            w_ctrl           = c_CTRL_FLUSH;
            w_incFlush       = 1'b1;
            w_nextBranchPend = 1'b0;
            w_nextRemaining  = 2'd0;
            w_nextState      = c_ST_RUN;
        end else if (w_effState == c_ST_STALL) begin
            w_ctrl          = c_CTRL_BUBBLE;
            w_incStall      = 1'b1;
            w_nextRemaining = r_remaining - 2'd1;
            w_nextState     = (r_remaining == 2'd1) ? c_ST_RUN : c_ST_STALL;
        end else if (w_hazard) begin
            w_ctrl     = c_CTRL_BUBBLE;
            w_incStall = 1'b1;
            if (LOAD_USE_STALLS > 1) begin
                w_nextRemaining = c_REM_LOAD;
                w_nextState     = c_ST_STALL;
            end
        end

        if (rst) begin
            w_ctrl     = c_CTRL_OFF;
            w_incStall = 1'b0;
            w_incFlush = 1'b0;
        end
    end

    assign pc_en         = w_ctrl.pcEn;
    assign pc_sel_branch = w_ctrl.pcSelBranch;
    assign if_id_en      = w_ctrl.ifIdEn;
    assign if_id_flush   = w_ctrl.ifIdFlush;
    assign id_ex_en      = w_ctrl.idExEn;
    assign id_ex_bubble  = w_ctrl.idExBubble;
    assign ex_mem_en     = w_ctrl.exMemEn;
    assign ex_mem_flush  = w_ctrl.exMemFlush;

    hazard_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stallCnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_incStall),
        .o_count (stall_cnt)
    );

    hazard_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flushCnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_incFlush),
        .o_count (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl. Two instances
//               (single-bubble/16-bit counters and three-bubble/4-bit
//               counters) share stimulus and are compared every cycle against
//               a behavioural model of stalls, flushes and memory freezes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memRead, mem_branch_taken, dmem_busy;

    logic        a_pc_en, a_pc_sel_branch, a_if_id_en, a_if_id_flush;
    logic        a_id_ex_en, a_id_ex_bubble, a_ex_mem_en, a_ex_mem_flush;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_pc_en, b_pc_sel_branch, b_if_id_en, b_if_id_flush;
    logic        b_id_ex_en, b_id_ex_bubble, b_ex_mem_en, b_ex_mem_flush;
    logic [3:0]  b_stall_cnt, b_flush_cnt;
    logic [7:0]  aCtrl, bCtrl;

    int checks = 0;
    int errors = 0;

    // Reference state per instance: index 0 = dutA, 1 = dutB
    int mLus[2] = '{1, 3};
    int mMax[2] = '{65535, 15};
    int mBub[2];
    int mPend[2];
    int mS[2];
    int mF[2];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(3), .LOAD_USE_STALLS(1), .IGNORE_R0(1), .CNT_W(16)
    ) dutA (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memRead(ex_memRead), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .dmem_busy(dmem_busy), .pc_en(a_pc_en), .pc_sel_branch(a_pc_sel_branch),
        .if_id_en(a_if_id_en), .if_id_flush(a_if_id_flush), .id_ex_en(a_id_ex_en),
        .id_ex_bubble(a_id_ex_bubble), .ex_mem_en(a_ex_mem_en), .ex_mem_flush(a_ex_mem_flush),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(3), .LOAD_USE_STALLS(3), .IGNORE_R0(1), .CNT_W(4)
    ) dutB (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memRead(ex_memRead), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .dmem_busy(dmem_busy), .pc_en(b_pc_en), .pc_sel_branch(b_pc_sel_branch),
        .if_id_en(b_if_id_en), .if_id_flush(b_if_id_flush), .id_ex_en(b_id_ex_en),
        .id_ex_bubble(b_id_ex_bubble), .ex_mem_en(b_ex_mem_en), .ex_mem_flush(b_ex_mem_flush),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    assign aCtrl = {a_pc_en, a_pc_sel_branch, a_if_id_en, a_if_id_flush,
                    a_id_ex_en, a_id_ex_bubble, a_ex_mem_en, a_ex_mem_flush};
    assign bCtrl = {b_pc_en, b_pc_sel_branch, b_if_id_en, b_if_id_flush,
                    b_id_ex_en, b_id_ex_bubble, b_ex_mem_en, b_ex_mem_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setIn(input bit mr, input logic [2:0] ert, input logic [2:0] rs,
                         input logic [2:0] rt, input bit uses, input bit tk, input bit busy);
        ex_memRead       = mr;
        ex_rt            = ert;
        id_rs            = rs;
        id_rt            = rt;
        id_uses_rt       = uses;
        mem_branch_taken = tk;
        dmem_busy        = busy;
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mBub[d] = 0; mPend[d] = 0; mS[d] = 0; mF[d] = 0;
        end
    endtask

    // Expected control vector {pcEn,pcSel,ifIdEn,ifIdFlush,idExEn,idExBubble,exMemEn,exMemFlush}
    task automatic modelStep(input int d, output logic [7:0] exp);
        bit hz;
        hz = ex_memRead && ((ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt)) && (ex_rt != 3'd0);
        if (dmem_busy) begin
            exp = 8'h00;
            if (mem_branch_taken) mPend[d] = 1;
        end else if (mem_branch_taken || mPend[d] != 0) begin
            exp = 8'hFF;
            mPend[d] = 0;
            mBub[d]  = 0;
            if (mF[d] < mMax[d]) mF[d]++;
        end else if (mBub[d] > 0 || hz) begin
            exp = 8'h0E;
            mBub[d] = (mBub[d] > 0) ? mBub[d] - 1 : mLus[d] - 1;
            if (mS[d] < mMax[d]) mS[d]++;
        end else begin
            exp = 8'hAA;
        end
    endtask

    // One clock: inputs already applied; check mid-cycle, then advance the model
    task automatic step(input string tag);
        logic [7:0] e;
        int s, f;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            s = mS[d];
            f = mF[d];
            modelStep(d, e);
            chk($sformatf("%s.%s.ctrl", tag, d != 0 ? "B" : "A"), d != 0 ? bCtrl : aCtrl, e);
            chk($sformatf("%s.%s.stall_cnt", tag, d != 0 ? "B" : "A"),
                d != 0 ? 32'(b_stall_cnt) : 32'(a_stall_cnt), s);
            chk($sformatf("%s.%s.flush_cnt", tag, d != 0 ? "B" : "A"),
                d != 0 ? 32'(b_flush_cnt) : 32'(a_flush_cnt), f);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkReset(input string tag);
        chk({tag, ".A.ctrl"}, aCtrl, 8'h00);
        chk({tag, ".B.ctrl"}, bCtrl, 8'h00);
        chk({tag, ".A.stall_cnt"}, 32'(a_stall_cnt), 0);
        chk({tag, ".B.stall_cnt"}, 32'(b_stall_cnt), 0);
        chk({tag, ".A.flush_cnt"}, 32'(a_flush_cnt), 0);
        chk({tag, ".B.flush_cnt"}, 32'(b_flush_cnt), 0);
    endtask

    task automatic idle(input int n);
        setIn(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) step("idle");
    endtask

    initial begin
        rst = 1'b1;
        setIn(0, 0, 0, 0, 0, 0, 0);
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkReset("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load-use on rs: single bubble on A, three on B
        idle(1);
        setIn(1, 3, 3, 0, 0, 0, 0); step("loadUseRs");
        idle(4);
        // rt matches but the instruction does not read rt
        setIn(1, 3, 4, 3, 0, 0, 0); step("rtUnused");
        idle(1);
        // rt matches and is read
        setIn(1, 5, 1, 5, 1, 0, 0); step("loadUseRt");
        idle(4);
        // Load into R0 never hazards
        setIn(1, 0, 0, 0, 1, 0, 0); step("r0Load");
        idle(1);

        // Branch in the same cycle as a hazard
        setIn(1, 2, 2, 0, 0, 1, 0); step("branchOverHz");
        idle(2);

        // Busy for four cycles, branch pulse in the second; flush on the fifth
        setIn(0, 0, 0, 0, 0, 0, 1); step("busy1");
        setIn(0, 0, 0, 0, 0, 1, 1); step("busy2");
        setIn(0, 0, 0, 0, 0, 0, 1); step("busy3");
        step("busy4");
        setIn(0, 0, 0, 0, 0, 0, 0); step("busyFlush");
        idle(1);

        // Busy in the middle of a three-bubble stall: remaining count resumes
        setIn(1, 6, 6, 0, 0, 0, 0); step("stallThenBusy");
        setIn(0, 0, 0, 0, 0, 0, 1); step("busyMidStall");
        step("busyMidStall2");
        idle(4);

        // Reset while dutB sits in STALL: outputs drop immediately
        setIn(1, 4, 4, 0, 0, 0, 0); step("preRst");
        #1;
        rst = 1'b1;
        #1;
        checkReset("rstMid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        idle(1);

        // Held hazard: dutB's 4-bit stall counter must stick at 15
        setIn(1, 7, 7, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("saturate");
        idle(3);

        // Randomized traffic on small register range to provoke matches
        for (int i = 0; i < 400; i++) begin
            setIn(($urandom % 2) == 0, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                  3'($urandom_range(0, 3)), ($urandom % 2) == 0,
                  ($urandom % 8) == 0, ($urandom % 6) == 0);
            step("random");
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
